// File: rtl/xalu_seq_if.sv
// Bundle between the wide-operation requester, the sequencer and the 4-bit slice.
// The slave modport is the sequencer's view; the master modport is the environment
// (requester plus slice) that surrounds it.
interface xalu_seq_if #(
    parameter int N = 4
);
    logic             start;
    logic [4*N-1:0]   a_in;
    logic [4*N-1:0]   b_in;
    logic [2:0]       func;
    logic             com;
    logic             cin;
    logic             busy;
    logic             done;
    logic [4*N-1:0]   result;
    logic             cout;
    logic             zero;
    logic             neg_zero;
    logic             equ;
    logic [3:0]       slc_a;
    logic [3:0]       slc_b;
    logic [2:0]       slc_f;
    logic             slc_com;
    logic             slc_ci_left;
    logic             slc_ci_right;
    logic [3:0]       slc_d;
    logic             slc_co_left;
    logic             slc_co_right;
    logic             slc_equ;

    modport slave (
        input  start, a_in, b_in, func, com, cin,
        input  slc_d, slc_co_left, slc_co_right, slc_equ,
        output busy, done, result, cout, zero, neg_zero, equ,
        output slc_a, slc_b, slc_f, slc_com, slc_ci_left, slc_ci_right
    );

    modport master (
        output start, a_in, b_in, func, com, cin,
        output slc_d, slc_co_left, slc_co_right, slc_equ,
        input  busy, done, result, cout, zero, neg_zero, equ,
        input  slc_a, slc_b, slc_f, slc_com, slc_ci_left, slc_ci_right
    );
endinterface

// File: rtl/xalu_seq.sv
// Multi-nibble sequencer: runs one 4N-bit operation through a single 4-bit ALU
// slice, one nibble per clock, chaining the slice carries between passes.
// SHR walks the nibbles MSB first so the shift-in travels downwards; everything
// else walks LSB first so the carry travels upwards.
module xalu_seq #(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    xalu_seq_if.slave   bus
);
    localparam int         W        = 4 * N;
    localparam logic [2:0] FN_ADD   = 3'd0;
    localparam logic [2:0] FN_SHR   = 3'd6;
    localparam logic [2:0] FN_SHL   = 3'd7;
    localparam logic [2:0] IDX_LAST = 3'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   shadow;
    logic [W-1:0]   shadow_next;
    logic [2:0]     f_reg;
    logic           com_reg;
    logic           cy;
    logic           cy_next;
    logic           zero_acc;
    logic           neg_acc;
    logic           equ_acc;
    logic [2:0]     idx;
    logic [2:0]     idx_first;
    logic [2:0]     idx_next;
    logic [3:0]     nib_a;
    logic [3:0]     nib_b;
    logic           is_shr;
    logic           accept;
    logic           last_pass;

    assign is_shr    = (f_reg == FN_SHR);
    assign accept    = (state == IDLE) && bus.start;
    assign last_pass = is_shr ? (idx == 3'd0) : (idx == IDX_LAST);
    assign idx_first = (bus.func == FN_SHR) ? IDX_LAST : 3'd0;
    assign idx_next  = is_shr ? (idx - 3'd1) : (idx + 3'd1);

    // State register; reset aborts any operation in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start is only looked at in IDLE, DONE always falls back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_pass) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: status flags and the slice drive, which is all zeros outside RUN.
    always_comb begin
        bus.busy         = (state != IDLE);
        bus.done         = (state == DONE);
        bus.slc_a        = 4'h0;
        bus.slc_b        = 4'h0;
        bus.slc_f        = 3'd0;
        bus.slc_com      = 1'b0;
        bus.slc_ci_left  = 1'b0;
        bus.slc_ci_right = 1'b0;
        if (state == RUN) begin
            bus.slc_a        = nib_a;
            bus.slc_b        = nib_b;
            bus.slc_f        = f_reg;
            bus.slc_com      = com_reg;
            bus.slc_ci_left  = is_shr ? cy : 1'b0;
            bus.slc_ci_right = is_shr ? 1'b0 : cy;
        end
    end

    // Nibble mux for the current pass and the shadow with this pass's slice data merged in.
    always_comb begin
        nib_a       = 4'h0;
        nib_b       = 4'h0;
        shadow_next = shadow;
        for (int k = 0; k < N; k++) begin
            if (idx == 3'(k)) begin
                nib_a                 = a_reg[4*k +: 4];
                nib_b                 = b_reg[4*k +: 4];
                shadow_next[4*k +: 4] = bus.slc_d;
            end
        end
    end

    // Carry chaining: arithmetic and left shift pass the left carry up, right shift
    // passes the right carry down, the logic and pass functions break the chain.
    always_comb begin
        cy_next = 1'b0;
        case (f_reg)
            FN_ADD, FN_SHL: cy_next = bus.slc_co_left;
            FN_SHR:         cy_next = bus.slc_co_right;
            default:        cy_next = 1'b0;
        endcase
    end

    // Working registers: capture the request on accept, then accumulate one nibble per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            f_reg    <= 3'd0;
            com_reg  <= 1'b0;
            cy       <= 1'b0;
            zero_acc <= 1'b0;
            neg_acc  <= 1'b0;
            equ_acc  <= 1'b0;
            idx      <= 3'd0;
            shadow   <= '0;
        end else if (accept) begin
            a_reg    <= bus.a_in;
            b_reg    <= bus.b_in;
            f_reg    <= bus.func;
            com_reg  <= bus.com;
            cy       <= bus.cin;
            zero_acc <= 1'b1;
            neg_acc  <= 1'b1;
            equ_acc  <= 1'b1;
            idx      <= idx_first;
            shadow   <= '0;
        end else if (state == RUN) begin
            shadow   <= shadow_next;
            cy       <= cy_next;
            zero_acc <= zero_acc & (bus.slc_d == 4'h0);
            neg_acc  <= neg_acc & (bus.slc_d == 4'hF);
            equ_acc  <= equ_acc & bus.slc_equ;
            idx      <= idx_next;
        end
    end

    // Visible results: loaded only on the final pass and held until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result   <= '0;
            bus.cout     <= 1'b0;
            bus.zero     <= 1'b0;
            bus.neg_zero <= 1'b0;
            bus.equ      <= 1'b0;
        end else if ((state == RUN) && last_pass) begin
            bus.result   <= shadow_next;
            bus.cout     <= cy_next;
            bus.zero     <= zero_acc & (bus.slc_d == 4'h0);
            bus.neg_zero <= neg_acc & (bus.slc_d == 4'hF);
            bus.equ      <= equ_acc & bus.slc_equ;
        end
    end
endmodule

// File: tb/tb_xalu_seq.sv
// Bench for xalu_seq: a behavioural 4-bit slice closes the loop around the DUT,
// a whole-word model predicts each operation, and directed vectors pin timing,
// shift order, start handling and mid-operation reset.
module tb_xalu_seq;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         nz;
        logic         equ;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    exp_t         expq[$];
    exp_t         e;
    logic [W-1:0] held = '0;

    logic         busy_log [0:31];
    logic         done_log [0:31];
    logic [3:0]   slca_log [0:31];

    logic [3:0]   s_d;
    logic         s_col;
    logic         s_cor;
    logic [4:0]   s_sum;

    xalu_seq_if #(.N(N)) bus();

    xalu_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit slice: the environment the sequencer drives nibble by nibble.
    always_comb begin
        s_d   = 4'h0;
        s_col = 1'b0;
        s_cor = 1'b0;
        s_sum = {1'b0, bus.slc_a} + {1'b0, bus.slc_b} + {4'b0, bus.slc_ci_right};
        case (bus.slc_f)
            3'd0: {s_col, s_d} = s_sum;
            3'd1: s_d = bus.slc_a & bus.slc_b;
            3'd2: s_d = bus.slc_a | bus.slc_b;
            3'd3: s_d = bus.slc_a ^ bus.slc_b;
            3'd4: s_d = bus.slc_a;
            3'd5: s_d = bus.slc_b;
            3'd6: begin
                s_d   = {bus.slc_ci_left, bus.slc_a[3:1]};
                s_cor = bus.slc_a[0];
            end
            default: begin
                s_d   = {bus.slc_a[2:0], bus.slc_ci_right};
                s_col = bus.slc_a[3];
            end
        endcase
        if (bus.slc_com) s_d = ~s_d;
    end

    assign bus.slc_d        = s_d;
    assign bus.slc_co_left  = s_col;
    assign bus.slc_co_right = s_cor;
    assign bus.slc_equ      = (bus.slc_a == bus.slc_b);

    // Whole-word reference: the wide operation computed directly on the full operands.
    function automatic exp_t model(input logic [2:0] f, input logic c,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci);
        exp_t       r;
        logic [W:0] wide;
        case (f)
            3'd0:    wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            3'd1:    wide = {1'b0, a & b};
            3'd2:    wide = {1'b0, a | b};
            3'd3:    wide = {1'b0, a ^ b};
            3'd4:    wide = {1'b0, a};
            3'd5:    wide = {1'b0, b};
            3'd6:    wide = {a[0], ci, a[W-1:1]};
            default: wide = {a, ci};
        endcase
        r.res  = c ? ~wide[W-1:0] : wide[W-1:0];
        r.cout = wide[W];
        r.zero = (r.res == '0);
        r.nz   = &r.res;
        r.equ  = (a == b);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare process: each done pulse must match the next predicted operation; in
    // between, result must hold its last value and the slice drive is quiet when idle.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            held = '0;
        end else begin
            if (bus.done) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("result", 32'(bus.result), 32'(e.res));
                    checkOutput("cout", 32'(bus.cout), 32'(e.cout));
                    checkOutput("zero", 32'(bus.zero), 32'(e.zero));
                    checkOutput("neg_zero", 32'(bus.neg_zero), 32'(e.nz));
                    checkOutput("equ", 32'(bus.equ), 32'(e.equ));
                    held = e.res;
                end
            end else begin
                checkOutput("result_hold", 32'(bus.result), 32'(held));
            end
            if (!bus.busy) begin
                checkOutput("slc_idle",
                            32'({bus.slc_a, bus.slc_b, bus.slc_f, bus.slc_com,
                                 bus.slc_ci_left, bus.slc_ci_right}), 32'd0);
            end
        end
    end

    // Waits (bounded) for IDLE, presents one request for exactly one accept edge.
    task automatic applyStimulus(input logic [2:0] f, input logic c,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci);
        int guard = 0;
        while (bus.busy && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (bus.busy) checkOutput("idle_wait_timeout", 32'd1, 32'd0);
        bus.func  = f;
        bus.com   = c;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.cin   = ci;
        bus.start = 1'b1;
        @(posedge clk);
        expq.push_back(model(f, c, a, b, ci));
        #1;
        bus.start = 1'b0;
    endtask

    // Logs busy/done/slc_a at the negedge of each of the next n cycles (index 1 = first after accept).
    task automatic observe(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            busy_log[c] = bus.busy;
            done_log[c] = bus.done;
            slca_log[c] = bus.slc_a;
        end
    endtask

    function automatic int count_busy(input int n);
        int s = 0;
        for (int c = 1; c <= n; c++) s += int'(busy_log[c]);
        return s;
    endfunction

    function automatic int count_done(input int n);
        int s = 0;
        for (int c = 1; c <= n; c++) s += int'(done_log[c]);
        return s;
    endfunction

    function automatic int first_done(input int n);
        for (int c = 1; c <= n; c++) if (done_log[c]) return c;
        return 0;
    endfunction

    // Directed sequence.
    initial begin
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.func  = 3'd0;
        bus.com   = 1'b0;
        bus.cin   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_result", 32'(bus.result), 32'd0);
        checkOutput("rst_flags", 32'({bus.cout, bus.zero, bus.neg_zero, bus.equ}), 32'd0);
        checkOutput("rst_slc", 32'({bus.slc_a, bus.slc_b, bus.slc_f, bus.slc_com,
                                    bus.slc_ci_left, bus.slc_ci_right}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD overflow wraps to zero, carry appears on cout; timing of busy/done.
        applyStimulus(3'd0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        observe(N + 2);
        checkOutput("t1_result", 32'(bus.result), 32'h0000);
        checkOutput("t1_cout", 32'(bus.cout), 32'd1);
        checkOutput("t1_zero", 32'(bus.zero), 32'd1);
        checkOutput("t1_busy_cycles", 32'(count_busy(N + 2)), 32'd5);
        checkOutput("t1_done_cycle", 32'(first_done(N + 2)), 32'd5);
        checkOutput("t1_done_count", 32'(count_done(N + 2)), 32'd1);

        // ADD with carry-in.
        applyStimulus(3'd0, 1'b0, 16'h1234, 16'h0FCC, 1'b1);
        observe(N + 2);
        checkOutput("t2_result", 32'(bus.result), 32'h2201);
        checkOutput("t2_flags", 32'({bus.cout, bus.zero, bus.equ}), 32'd0);

        // SHL then SHR, including the MSB-first nibble order of SHR.
        applyStimulus(3'd7, 1'b0, 16'h8001, 16'h0000, 1'b1);
        observe(N + 2);
        checkOutput("t3_shl_result", 32'(bus.result), 32'h0003);
        checkOutput("t3_shl_cout", 32'(bus.cout), 32'd1);
        applyStimulus(3'd6, 1'b0, 16'h8001, 16'h0000, 1'b0);
        observe(N + 2);
        checkOutput("t3_shr_result", 32'(bus.result), 32'h4000);
        checkOutput("t3_shr_cout", 32'(bus.cout), 32'd1);
        checkOutput("t3_shr_slc_a_order",
                    32'({slca_log[1], slca_log[2], slca_log[3], slca_log[4]}), 32'h8001);

        // Inverted XOR of equal operands, then PASSB of zero.
        applyStimulus(3'd3, 1'b1, 16'h5A5A, 16'h5A5A, 1'b0);
        observe(N + 2);
        checkOutput("t4_result", 32'(bus.result), 32'hFFFF);
        checkOutput("t4_nz_equ_cout", 32'({bus.neg_zero, bus.equ, bus.cout}), 32'b110);
        applyStimulus(3'd5, 1'b0, 16'h1234, 16'h0000, 1'b1);
        observe(N + 2);
        checkOutput("t4_passb_zero", 32'(bus.zero), 32'd1);

        // Remaining functions, checked through the model only.
        applyStimulus(3'd1, 1'b0, 16'hF0F0, 16'h3C3C, 1'b1);
        observe(N + 2);
        applyStimulus(3'd2, 1'b0, 16'h0F00, 16'h00F1, 1'b1);
        observe(N + 2);
        applyStimulus(3'd4, 1'b1, 16'hA5C3, 16'h0000, 1'b1);
        observe(N + 2);
        checkOutput("t5_passa_com", 32'(bus.result), 32'h5A3C);

        // start held high: the second request waits for IDLE, operands of the first stay put.
        bus.func  = 3'd0;
        bus.com   = 1'b0;
        bus.a_in  = 16'h0001;
        bus.b_in  = 16'h0002;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        expq.push_back(model(3'd0, 1'b0, 16'h0001, 16'h0002, 1'b0));
        expq.push_back(model(3'd2, 1'b0, 16'h00F0, 16'h0F00, 1'b0));
        #1;
        bus.func = 3'd2;
        bus.a_in = 16'h00F0;
        bus.b_in = 16'h0F00;
        for (int c = 1; c <= 2 * N + 3; c++) begin
            @(negedge clk);
            busy_log[c] = bus.busy;
            done_log[c] = bus.done;
            if (c == N + 2) begin
                @(posedge clk);
                #1 bus.start = 1'b0;
            end
        end
        checkOutput("t6_first_done", 32'(first_done(2 * N + 3)), 32'(N + 1));
        checkOutput("t6_idle_gap", 32'(busy_log[N + 2]), 32'd0);
        checkOutput("t6_second_done", 32'(done_log[2 * N + 3]), 32'd1);
        checkOutput("t6_done_count", 32'(count_done(2 * N + 3)), 32'd2);
        checkOutput("t6_result", 32'(bus.result), 32'h0FF0);

        // Reset at the second RUN edge aborts the ADD; a fresh ADD then completes.
        applyStimulus(3'd0, 1'b0, 16'h00FF, 16'h0001, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t7_busy", 32'(bus.busy), 32'd0);
        checkOutput("t7_done", 32'(bus.done), 32'd0);
        checkOutput("t7_result", 32'(bus.result), 32'd0);
        checkOutput("t7_flags", 32'({bus.cout, bus.zero, bus.neg_zero, bus.equ}), 32'd0);
        checkOutput("t7_slc", 32'({bus.slc_a, bus.slc_b, bus.slc_f, bus.slc_com,
                                   bus.slc_ci_left, bus.slc_ci_right}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        observe(N + 2);
        checkOutput("t7_no_done", 32'(count_done(N + 2)), 32'd0);
        checkOutput("t7_stays_idle", 32'(count_busy(N + 2)), 32'd0);
        applyStimulus(3'd0, 1'b0, 16'h00FF, 16'h0001, 1'b0);
        observe(N + 2);
        checkOutput("t7_after_result", 32'(bus.result), 32'h0100);
        checkOutput("t7_after_done", 32'(count_done(N + 2)), 32'd1);

        checkOutput("queue_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
